// File: rtl/window_streamer_pkg.sv
// Shared types and geometry helpers for the sliding-window streamer.
// Used by window_streamer and win_gather; padding is enabled by WINDOW_STREAMER_PAD_EN.
package window_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int calc_out_h(input int img_h, input int k_h,
                                    input int stride_h, input int pad);
    return (img_h + 2 * pad - k_h) / stride_h + 1;
  endfunction

  function automatic int calc_out_w(input int img_w, input int k_w,
                                    input int stride_w, input int pad);
    return (img_w + 2 * pad - k_w) / stride_w + 1;
  endfunction

  // Index width for a counter over n positions, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_streamer_win_gather.sv
// Combinational tap selection: builds one K_H x K_W window per channel from the image buffer.
// Out-of-image taps read zero only when WINDOW_STREAMER_PAD_EN is defined.
module win_gather
  import window_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int IMG_H      = 8,
  parameter int IMG_W      = 8,
  parameter int K_H        = 3,
  parameter int K_W        = 3,
  parameter int STRIDE_H   = 1,
  parameter int STRIDE_W   = 1,
  parameter int PAD        = 0,
  localparam int OUT_H     = calc_out_h(IMG_H, K_H, STRIDE_H, PAD),
  localparam int OUT_W     = calc_out_w(IMG_W, K_W, STRIDE_W, PAD),
  localparam int RW        = idx_w(OUT_H),
  localparam int CW        = idx_w(OUT_W),
  localparam int NPIX      = CHANNELS * IMG_H * IMG_W,
  localparam int NTAP      = CHANNELS * K_H * K_W
) (
  input  logic [NPIX*DATA_WIDTH-1:0] buf_i,
  input  logic [RW-1:0]              row_i,
  input  logic [CW-1:0]              col_i,
  output logic [NTAP*DATA_WIDTH-1:0] win_o
);

  localparam int IW = idx_w(NPIX);

  logic [DATA_WIDTH-1:0] pix [NPIX];

  for (genvar p = 0; p < NPIX; p++) begin : g_pix
    assign pix[p] = buf_i[p*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar t = 0; t < NTAP; t++) begin : g_tap
    localparam int C = t / (K_H * K_W);
    localparam int I = (t / K_W) % K_H;
    localparam int J = t % K_W;

    int                    y;
    int                    x;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] tap;
`ifdef WINDOW_STREAMER_PAD_EN
    logic                  inb;
`endif

    always_comb begin
      y = int'(row_i) * STRIDE_H + I - PAD;
      x = int'(col_i) * STRIDE_W + J - PAD;
`ifdef WINDOW_STREAMER_PAD_EN
      inb = (y >= 0) && (y < IMG_H) && (x >= 0) && (x < IMG_W);
      // Clamp so the buffer read stays in range; the result is masked anyway.
      if (!inb) begin
        y = 0;
        x = 0;
      end
`endif
      idx = IW'((C * IMG_H + y) * IMG_W + x);
`ifdef WINDOW_STREAMER_PAD_EN
      tap = inb ? pix[idx] : '0;
`else
      tap = pix[idx];
`endif
    end

    assign win_o[t*DATA_WIDTH +: DATA_WIDTH] = tap;
  end

endmodule

// File: rtl/window_streamer.sv
// Captures an image, then streams every K_H x K_W window in row-major order with ready/valid.
// Zero padding (PAD > 0) requires the macro WINDOW_STREAMER_PAD_EN.
module window_streamer
  import window_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int IMG_H      = 8,
  parameter int IMG_W      = 8,
  parameter int K_H        = 3,
  parameter int K_W        = 3,
  parameter int STRIDE_H   = 1,
  parameter int STRIDE_W   = 1,
  parameter int PAD        = 0,
`ifdef WINDOW_STREAMER_PAD_EN
  localparam int PAD_EFF   = PAD,
`else
  localparam int PAD_EFF   = 0,
`endif
  localparam int OUT_H     = calc_out_h(IMG_H, K_H, STRIDE_H, PAD_EFF),
  localparam int OUT_W     = calc_out_w(IMG_W, K_W, STRIDE_W, PAD_EFF),
  localparam int RW        = idx_w(OUT_H),
  localparam int CW        = idx_w(OUT_W),
  localparam int IMG_BITS  = CHANNELS * IMG_H * IMG_W * DATA_WIDTH,
  localparam int WIN_BITS  = CHANNELS * K_H * K_W * DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IMG_BITS-1:0] image_flat,
  input  logic                out_ready,
  output logic [WIN_BITS-1:0] window_flat,
  output logic                window_valid,
  output logic [RW-1:0]       win_row,
  output logic [CW-1:0]       win_col,
  output logic                last_window,
  output logic                busy,
  output logic                all_done
);

`ifndef WINDOW_STREAMER_PAD_EN
  if (PAD != 0) begin : g_pad_check
    $error("window_streamer: PAD=%0d needs WINDOW_STREAMER_PAD_EN", PAD);
  end
`endif

  localparam logic ONE_WIN = (OUT_H == 1) && (OUT_W == 1);

  state_t                state_q;
  logic [IMG_BITS-1:0]   buf_q;
  logic [WIN_BITS-1:0]   win_q;
  logic                  vld_q;
  logic [RW-1:0]         row_q;
  logic [CW-1:0]         col_q;
  logic                  last_q;
  logic                  busy_q;
  logic                  done_q;

  logic [RW-1:0]         row_d;
  logic [CW-1:0]         col_d;
  logic                  last_d;
  logic [RW-1:0]         g_row;
  logic [CW-1:0]         g_col;
  logic [WIN_BITS-1:0]   g_win;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (col_q == CW'(OUT_W - 1)) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
    last_d = (row_d == RW'(OUT_H - 1)) && (col_d == CW'(OUT_W - 1));
  end

  // LOAD gathers window (0,0); EMIT always prepares the successor of the current window.
  assign g_row = (state_q == EMIT) ? row_d : '0;
  assign g_col = (state_q == EMIT) ? col_d : '0;

  win_gather #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHANNELS   (CHANNELS),
    .IMG_H      (IMG_H),
    .IMG_W      (IMG_W),
    .K_H        (K_H),
    .K_W        (K_W),
    .STRIDE_H   (STRIDE_H),
    .STRIDE_W   (STRIDE_W),
    .PAD        (PAD_EFF)
  ) u_gather (
    .buf_i (buf_q),
    .row_i (g_row),
    .col_i (g_col),
    .win_o (g_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      vld_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            buf_q   <= image_flat;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          win_q   <= g_win;
          row_q   <= '0;
          col_q   <= '0;
          vld_q   <= 1'b1;
          last_q  <= ONE_WIN;
          state_q <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (last_q) begin
              win_q   <= '0;
              vld_q   <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              win_q  <= g_win;
              row_q  <= row_d;
              col_q  <= col_d;
              last_q <= last_d;
            end
          end
        end
        DONE: begin
          row_q   <= '0;
          col_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign window_flat  = win_q;
  assign window_valid = vld_q;
  assign win_row      = row_q;
  assign win_col      = col_q;
  assign last_window  = last_q;
  assign busy         = busy_q;
  assign all_done     = done_q;

endmodule

// File: tb/tb_window_streamer.sv
// Scoreboard bench for window_streamer: default, stride-2, single-window and (with
// WINDOW_STREAMER_PAD_EN) a padded two-channel configuration, run one after another.
module tb_window_streamer;

  typedef struct {
    int ch; int ih; int iw; int kh; int kw; int sh; int sw; int pad;
  } cfg_t;

  typedef struct {
    int           row;
    int           col;
    logic         last;
    logic [143:0] win;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic rdy;
  int   sel;
  bit   mon_en;
  int   n_err;
  int   n_checks;

  cfg_t cfgs [4];
  exp_t sbq [$];
  logic [7:0] img [2][8][8];

  logic [511:0] img8_flat;
  logic [255:0] img4_flat;
  logic [71:0]  img3_flat;

  logic st0, st1, st2, st3;
  logic [71:0]  w0, w1, w3;
  logic [143:0] w2;
  logic [2:0]   r0, c0;
  logic [1:0]   r1, c1, r2, c2;
  logic         r3, c3;
  logic v0, v1, v2, v3, l0, l1, l2, l3, b0, b1, b2, b3, d0, d1, d2, d3;

  logic [143:0] m_win;
  logic         m_vld, m_last, m_busy, m_done;
  int           m_row, m_col;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign st0 = start & (sel == 0);
  assign st1 = start & (sel == 1);
  assign st2 = start & (sel == 2);
  assign st3 = start & (sel == 3);

  always_comb begin
    img8_flat = '0;
    img4_flat = '0;
    img3_flat = '0;
    for (int r = 0; r < 8; r++)
      for (int x = 0; x < 8; x++)
        img8_flat = img8_flat | (512'(img[0][r][x]) << (8 * (r * 8 + x)));
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r++)
        for (int x = 0; x < 4; x++)
          img4_flat = img4_flat | (256'(img[c][r][x]) << (8 * ((c * 4 + r) * 4 + x)));
    for (int r = 0; r < 3; r++)
      for (int x = 0; x < 3; x++)
        img3_flat = img3_flat | (72'(img[0][r][x]) << (8 * (r * 3 + x)));
  end

  window_streamer u_dut0 (
    .clk(clk), .rst(rst), .start(st0), .image_flat(img8_flat), .out_ready(rdy),
    .window_flat(w0), .window_valid(v0), .win_row(r0), .win_col(c0),
    .last_window(l0), .busy(b0), .all_done(d0)
  );

  window_streamer #(.STRIDE_H(2), .STRIDE_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(st1), .image_flat(img8_flat), .out_ready(rdy),
    .window_flat(w1), .window_valid(v1), .win_row(r1), .win_col(c1),
    .last_window(l1), .busy(b1), .all_done(d1)
  );

  window_streamer #(.IMG_H(3), .IMG_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(st3), .image_flat(img3_flat), .out_ready(rdy),
    .window_flat(w3), .window_valid(v3), .win_row(r3), .win_col(c3),
    .last_window(l3), .busy(b3), .all_done(d3)
  );

`ifdef WINDOW_STREAMER_PAD_EN
  window_streamer #(.CHANNELS(2), .IMG_H(4), .IMG_W(4), .PAD(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(st2), .image_flat(img4_flat), .out_ready(rdy),
    .window_flat(w2), .window_valid(v2), .win_row(r2), .win_col(c2),
    .last_window(l2), .busy(b2), .all_done(d2)
  );
`else
  assign w2 = '0;
  assign v2 = 1'b0;
  assign r2 = '0;
  assign c2 = '0;
  assign l2 = 1'b0;
  assign b2 = 1'b0;
  assign d2 = 1'b0;
`endif

  always_comb begin
    m_win = '0; m_vld = 1'b0; m_last = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_row = 0; m_col = 0;
    case (sel)
      0: begin m_win = 144'(w0); m_vld = v0; m_last = l0; m_busy = b0; m_done = d0;
               m_row = int'(r0); m_col = int'(c0); end
      1: begin m_win = 144'(w1); m_vld = v1; m_last = l1; m_busy = b1; m_done = d1;
               m_row = int'(r1); m_col = int'(c1); end
      2: begin m_win = w2; m_vld = v2; m_last = l2; m_busy = b2; m_done = d2;
               m_row = int'(r2); m_col = int'(c2); end
      default: begin m_win = 144'(w3); m_vld = v3; m_last = l3; m_busy = b3; m_done = d3;
               m_row = int'(r3); m_col = int'(c3); end
    endcase
  end

  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_image(input int off);
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 8; r++)
        for (int x = 0; x < 8; x++)
          img[c][r][x] = 8'(c * 64 + r * 8 + x + off);
  endtask

  function automatic logic [143:0] model_win(input cfg_t c, input int wr, input int wc);
    logic [143:0] w;
    int y, x, off;
    w = '0;
    for (int ch = 0; ch < c.ch; ch++)
      for (int i = 0; i < c.kh; i++)
        for (int j = 0; j < c.kw; j++) begin
          y = wr * c.sh + i - c.pad;
          x = wc * c.sw + j - c.pad;
          off = 8 * ((ch * c.kh + i) * c.kw + j);
          if (y >= 0 && y < c.ih && x >= 0 && x < c.iw)
            w = w | (144'(img[ch][y][x]) << off);
        end
    return w;
  endfunction

  task automatic push_scan();
    cfg_t c;
    exp_t e;
    int   oh, ow;
    c  = cfgs[sel];
    oh = (c.ih + 2 * c.pad - c.kh) / c.sh + 1;
    ow = (c.iw + 2 * c.pad - c.kw) / c.sw + 1;
    for (int r = 0; r < oh; r++)
      for (int cc = 0; cc < ow; cc++) begin
        e.row  = r;
        e.col  = cc;
        e.last = (r == oh - 1) && (cc == ow - 1);
        e.win  = model_win(c, r, cc);
        sbq.push_back(e);
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, output int n);
    n = 0;
    while (!m_done && n < 400) begin
      if (rnd) rdy = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    rdy = 1'b1;
    check("all_done_seen", m_done, 1);
  endtask

  task automatic wait_queue(input int target);
    int k;
    k = 0;
    while (sbq.size() > target && k < 200) begin
      tick();
      k++;
    end
    check("reach_window", sbq.size(), target);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_vld"}, m_vld, 0);
    check({tag, "_win"}, m_win, 0);
    check({tag, "_row"}, m_row, 0);
    check({tag, "_col"}, m_col, 0);
    check({tag, "_last"}, m_last, 0);
    check({tag, "_busy"}, m_busy, 0);
    check({tag, "_done"}, m_done, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (m_vld) begin
        if (sbq.size() == 0) begin
          check("extra_window", 1, 0);
        end else begin
          e = sbq[0];
          check("win_row", m_row, e.row);
          check("win_col", m_col, e.col);
          check("window_flat", m_win, e.win);
          check("last_window", m_last, e.last);
          if (sel == 1 && m_row == 1 && m_col == 2) check("s2_origin_pix", m_win[7:0], 20);
          if (rdy) void'(sbq.pop_front());
        end
      end else begin
        check("last_without_valid", m_last, 0);
      end
    end
  end

  initial begin
    int n;
    logic [143:0] snap_win;
    int snap_row, snap_col;

    cfgs[0] = '{1, 8, 8, 3, 3, 1, 1, 0};
    cfgs[1] = '{1, 8, 8, 3, 3, 2, 2, 0};
    cfgs[2] = '{2, 4, 4, 3, 3, 1, 1, 1};
    cfgs[3] = '{1, 3, 3, 3, 3, 1, 1, 0};
    n_err = 0; n_checks = 0;
    sel = 0; rst = 1'b1; start = 1'b0; rdy = 1'b1; mon_en = 1'b0;
    set_image(0);
    repeat (3) tick();
    check_reset_state("rst");
    rst = 1'b0;

    // Full default scan; image altered right after capture.
    push_scan();
    check("n_win_default", sbq.size(), 36);
    mon_en = 1'b1;
    pulse_start();
    set_image(100);
    check("load_vld", m_vld, 0);
    check("load_busy", m_busy, 1);
    tick();
    check("first_vld", m_vld, 1);
    check("first_win", m_win, 144'h121110_0a0908_020100);
    wait_done(0, n);
    check("done_cycles", n, 36);
    check("sb_empty_1", sbq.size(), 0);
    check("done_win_clear", m_win, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_one_cycle", m_done, 0);
    check("idle_busy", m_busy, 0);
    tick();
    check("done_start_ignored_vld", m_vld, 0);
    check("done_start_ignored_busy", m_busy, 0);

    // Backpressure at window 3 for five cycles.
    set_image(0);
    push_scan();
    pulse_start();
    wait_queue(34);
    rdy = 1'b0;
    snap_win = m_win; snap_row = m_row; snap_col = m_col;
    check("stall_at_row", snap_row, 0);
    check("stall_at_col", snap_col, 2);
    repeat (5) begin
      tick();
      check("stall_win", m_win, snap_win);
      check("stall_row", m_row, snap_row);
      check("stall_col", m_col, snap_col);
    end
    rdy = 1'b1;
    wait_done(0, n);
    check("stall_done_cycles", n, 34);
    check("sb_empty_2", sbq.size(), 0);
    tick();

    // Reset at window 10, with start held high during reset.
    push_scan();
    pulse_start();
    wait_queue(27);
    mon_en = 1'b0;
    sbq.delete();
    rst = 1'b1;
    start = 1'b1;
    tick();
    check_reset_state("midrst");
    tick();
    check("rst_over_start_busy", m_busy, 0);
    rst = 1'b0;
    start = 1'b0;
    tick();
    push_scan();
    mon_en = 1'b1;
    pulse_start();
    check("restart_load_vld", m_vld, 0);
    tick();
    check("restart_vld", m_vld, 1);
    check("restart_row", m_row, 0);
    check("restart_col", m_col, 0);
    repeat (4) tick();
    pulse_start();
    wait_done(0, n);
    check("sb_empty_3", sbq.size(), 0);
    tick();

    // Stride 2 with random backpressure.
    sel = 1;
    tick();
    push_scan();
    check("n_win_stride2", sbq.size(), 9);
    pulse_start();
    wait_done(1, n);
    check("sb_empty_4", sbq.size(), 0);
    tick();

    // Single-window geometry.
    sel = 3;
    tick();
    push_scan();
    check("n_win_single", sbq.size(), 1);
    pulse_start();
    tick();
    check("single_last", m_last, 1);
    wait_done(0, n);
    check("single_done_cycles", n, 1);
    check("sb_empty_5", sbq.size(), 0);
    tick();

`ifdef WINDOW_STREAMER_PAD_EN
    // Two channels, 4x4 image, one-pixel zero border.
    sel = 2;
    set_image(1);
    tick();
    push_scan();
    check("n_win_pad", sbq.size(), 16);
    pulse_start();
    tick();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 3; k++) begin
        check("pad_row0_zero", (m_win >> (8 * ((c * 3 + 0) * 3 + k))) & 144'hff, 0);
        check("pad_col0_zero", (m_win >> (8 * ((c * 3 + k) * 3 + 0))) & 144'hff, 0);
      end
      check("pad_center", (m_win >> (8 * ((c * 3 + 1) * 3 + 1))) & 144'hff, c * 64 + 1);
    end
    wait_done(1, n);
    check("sb_empty_6", sbq.size(), 0);
    tick();
`endif

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
